// File: rtl/serial_transmitter_pkg.sv
// Shared definitions for the serial transmitter/receiver pair: frame length,
// the CLOG2 helper and the transmitter FSM state type.
package serial_transmitter_pkg;

    // Frame is a 16-bit flip index followed by one byte of input vector.
    localparam int unsigned FLIP_IDX_BYTES = 2;
    localparam int unsigned INPUT_BYTES    = 1;
    localparam int unsigned FRAME_BYTES    = FLIP_IDX_BYTES + INPUT_BYTES;
    localparam int unsigned FRAME_LEN      = FRAME_BYTES * 8;

    // ceil(log2(value)); value must be at least 2 to give a non-zero width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow,
        StDone
    } tx_state_e;

endpackage

// File: rtl/sclk_divider.sv
// Phase counter: while enabled, emits a phase_end strobe every CLK_DIV cycles.
module sclk_divider
    import serial_transmitter_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic flip_clk,
    input  logic reset,
    input  logic i_enable,
    output logic o_phase_end
);

    localparam int unsigned CNT_W = clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last      = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign o_phase_end = i_enable && w_last;

    // Held at zero while disabled so every phase starts from a full count.
    always_ff @(posedge flip_clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!i_enable || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// Companion receiver: shifts sda in, MSB first, on each falling edge of sclk
// seen in the flip_clk domain, and pulses frame_valid after DATA_LEN bits.
module serial_receiver
    import serial_transmitter_pkg::*;
#(
    parameter int unsigned DATA_LEN = FRAME_LEN
) (
    input  logic                flip_clk,
    input  logic                reset,
    input  logic                sclk,
    input  logic                sda,
    output logic [DATA_LEN-1:0] data_out,
    output logic                frame_valid
);

    localparam int unsigned BIT_W = clog2(DATA_LEN + 1);

    logic                r_sclk_prev;
    logic [DATA_LEN-1:0] r_shift;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic                r_valid;
    logic                w_fall;
    logic                w_last_bit;

    assign w_fall     = r_sclk_prev && !sclk;
    assign w_last_bit = (r_bit_cnt == BIT_W'(DATA_LEN - 1));

    always_ff @(posedge flip_clk or negedge reset) begin
        if (!reset) begin
            r_sclk_prev <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_sclk_prev <= sclk;
            r_valid     <= w_fall && w_last_bit;
            if (w_fall) begin
                r_shift   <= {r_shift[DATA_LEN-2:0], sda};
                r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
            end
        end
    end

    assign data_out    = r_shift;
    assign frame_valid = r_valid;

endmodule

// File: rtl/serial_transmitter.sv
// Serial frame transmitter: sends DATA_LEN bits MSB first on sda, with sda
// changing only as sclk rises so the receiver samples on the falling edge.
module serial_transmitter
    import serial_transmitter_pkg::*;
#(
    parameter int unsigned DATA_LEN = FRAME_LEN,
    parameter int unsigned CLK_DIV  = 4
) (
    input  logic                flip_clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DATA_LEN-1:0] data_in,
    output logic                busy,
    output logic                done,
    output logic                sda,
    output logic                sclk
);

    localparam int unsigned BIT_W = clog2(DATA_LEN + 1);

    tx_state_e           r_state;
    tx_state_e           w_state_next;
    logic [DATA_LEN-1:0] r_tx;
    logic [DATA_LEN-1:0] w_tx_next;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [BIT_W-1:0]    w_bit_cnt_next;
    logic                r_sclk;
    logic                w_sclk_next;
    logic                r_sda;
    logic                w_sda_next;
    logic                r_busy;
    logic                w_busy_next;
    logic                r_done;
    logic                w_done_next;

    logic                w_div_en;
    logic                w_phase_end;
    logic [BIT_W-1:0]    w_bit_dec;
    logic [DATA_LEN-1:0] w_tx_shift;

    assign w_div_en   = (r_state == StHigh) || (r_state == StLow);
    assign w_bit_dec  = r_bit_cnt - 1'b1;
    assign w_tx_shift = r_tx >> w_bit_dec;

    sclk_divider #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_divider (
        .flip_clk   (flip_clk),
        .reset      (reset),
        .i_enable   (w_div_en),
        .o_phase_end(w_phase_end)
    );

    // Outputs are computed one state ahead so they come straight from flops.
    always_comb begin
        w_state_next   = r_state;
        w_tx_next      = r_tx;
        w_bit_cnt_next = r_bit_cnt;
        w_sclk_next    = r_sclk;
        w_sda_next     = r_sda;
        w_busy_next    = r_busy;
        w_done_next    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next   = StHigh;
                    w_tx_next      = data_in;
                    w_bit_cnt_next = BIT_W'(DATA_LEN - 1);
                    w_sclk_next    = 1'b1;
                    w_sda_next     = data_in[DATA_LEN-1];
                    w_busy_next    = 1'b1;
                end
            end
            StHigh: begin
                if (w_phase_end) begin
                    w_state_next = StLow;
                    w_sclk_next  = 1'b0;
                end
            end
            StLow: begin
                if (w_phase_end) begin
                    if (r_bit_cnt == '0) begin
                        w_state_next = StDone;
                        w_sclk_next  = 1'b0;
                        w_sda_next   = 1'b0;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next   = StHigh;
                        w_bit_cnt_next = w_bit_dec;
                        w_sclk_next    = 1'b1;
                        w_sda_next     = w_tx_shift[0];
                    end
                end
            end
            StDone: begin
                w_state_next = StIdle;
                w_sclk_next  = 1'b0;
                w_sda_next   = 1'b0;
                w_busy_next  = 1'b0;
            end
            default: begin
                w_state_next = StIdle;
                w_sclk_next  = 1'b0;
                w_sda_next   = 1'b0;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge flip_clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_tx      <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_sda     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_tx      <= w_tx_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_sclk    <= w_sclk_next;
            r_sda     <= w_sda_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    assign sclk = r_sclk;
    assign sda  = r_sda;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter at CLK_DIV=2 and CLK_DIV=1, each looped into a
// serial_receiver, checked cycle by cycle against a frame-timeline model.
module tb_serial_transmitter;

    localparam int N = 24;

    logic          flip_clk = 1'b0;
    logic          reset    = 1'b1;
    logic          start    = 1'b0;
    logic [N-1:0]  data_in  = '0;
    logic [1:0]    w_sclk;
    logic [1:0]    w_sda;
    logic [1:0]    w_busy;
    logic [1:0]    w_done;
    logic [1:0]    w_valid;
    logic [N-1:0]  w_rx [2];

    serial_transmitter #(.DATA_LEN(N), .CLK_DIV(2)) u_dut2 (
        .flip_clk(flip_clk), .reset(reset), .start(start), .data_in(data_in),
        .busy(w_busy[0]), .done(w_done[0]), .sda(w_sda[0]), .sclk(w_sclk[0])
    );
    serial_transmitter #(.DATA_LEN(N), .CLK_DIV(1)) u_dut1 (
        .flip_clk(flip_clk), .reset(reset), .start(start), .data_in(data_in),
        .busy(w_busy[1]), .done(w_done[1]), .sda(w_sda[1]), .sclk(w_sclk[1])
    );
    serial_receiver #(.DATA_LEN(N)) u_rx2 (
        .flip_clk(flip_clk), .reset(reset), .sclk(w_sclk[0]), .sda(w_sda[0]),
        .data_out(w_rx[0]), .frame_valid(w_valid[0])
    );
    serial_receiver #(.DATA_LEN(N)) u_rx1 (
        .flip_clk(flip_clk), .reset(reset), .sclk(w_sclk[1]), .sda(w_sda[1]),
        .data_out(w_rx[1]), .frame_valid(w_valid[1])
    );

    always #5 flip_clk = ~flip_clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Expected {sclk, sda, busy, done} k cycles after the accept cycle.
    function automatic logic [3:0] expect_out(input bit act, input int k, input int d,
                                              input logic [N-1:0] data);
        int j;
        int ph;
        if (!act) return 4'b0000;
        if (k <= 2 * d * N) begin
            j  = (k - 1) / (2 * d);
            ph = (k - 1) % (2 * d);
            return {(ph < d) ? 1'b1 : 1'b0, data[N-1-j], 1'b1, 1'b0};
        end
        return 4'b0001;
    endfunction

    int           cyc = 0;
    bit           m_act  [2];
    int           m_k    [2];
    logic [N-1:0] m_data [2];
    int           m_acc  [2];

    always @(posedge flip_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 1'b0;
                m_k[i]   = 0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (!m_act[i]) begin
                    if (start) begin
                        m_act[i]  = 1'b1;
                        m_k[i]    = 1;
                        m_data[i] = data_in;
                        m_acc[i]  = cyc;
                    end
                end else begin
                    m_k[i]++;
                    if (m_k[i] > 2 * div_of(i) * N + 1) m_act[i] = 1'b0;
                end
            end
        end
    end

    logic [1:0]   prev_sclk = 2'b00;
    int           m_falls [2];
    logic [N-1:0] m_rx    [2];
    int           n_done  [2];
    int           n_valid [2];

    always @(negedge flip_clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                if (m_act[i] && m_k[i] == 1) begin
                    m_falls[i] = 0;
                    m_rx[i]    = '0;
                end
                if (prev_sclk[i] && !w_sclk[i]) begin
                    m_falls[i]++;
                    m_rx[i] = {m_rx[i][N-2:0], w_sda[i]};
                end
                prev_sclk[i] = w_sclk[i];
                check_eq($sformatf("out%0d_k%0d", i, m_k[i]),
                         32'({w_sclk[i], w_sda[i], w_busy[i], w_done[i]}),
                         32'(expect_out(m_act[i], m_k[i], div_of(i), m_data[i])));
                if (w_valid[i]) n_valid[i]++;
                if (w_done[i]) begin
                    n_done[i]++;
                    check_eq($sformatf("done_lat%0d", i), 32'(cyc - m_acc[i] + 1),
                             32'(1 + 2 * div_of(i) * N));
                    check_eq($sformatf("falls%0d", i), 32'(m_falls[i]), 32'(N));
                    check_eq($sformatf("sda_word%0d", i), 32'(m_rx[i]), 32'(m_data[i]));
                    check_eq($sformatf("rx_data%0d", i), 32'(w_rx[i]), 32'(m_data[i]));
                end
            end
        end
    end

    // sda must never move on the edge that drops sclk.
    a_sda_hold2: assert property (@(posedge flip_clk) disable iff (!reset)
        $fell(w_sclk[0]) |-> $stable(w_sda[0])) else $error("sda moved on sclk fall, div 2");
    a_sda_hold1: assert property (@(posedge flip_clk) disable iff (!reset)
        $fell(w_sclk[1]) |-> $stable(w_sda[1])) else $error("sda moved on sclk fall, div 1");

    task automatic tick(input int n = 1);
        repeat (n) @(posedge flip_clk);
        #1;
    endtask

    task automatic pulse_start(input logic [N-1:0] d);
        data_in = d;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_falls[i] = 0;
            m_rx[i]    = '0;
            n_done[i]  = 0;
            n_valid[i] = 0;
        end
        #2 reset = 1'b0;
        chk_en = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(2);

        // Basic frame; data_in scrambled right after accept.
        pulse_start(24'hA5C3F0);
        data_in = 24'h0F0F0F;
        tick(110);
        pulse_start(24'h800001);
        tick(110);

        // Start pulses mid-frame must be ignored.
        pulse_start(24'hC0FFEE);
        tick(4);
        pulse_start(24'h111111);
        tick(13);
        pulse_start(24'h222222);
        tick(19);
        pulse_start(24'h333333);
        tick(70);

        // Start held high: back-to-back frames pick up the new payload.
        data_in = 24'h5A5A5A;
        start   = 1'b1;
        tick();
        data_in = 24'h00FFFF;
        tick(2 * 97 + 3);
        start = 1'b0;
        tick(110);

        // Reset during bit 10, HIGH phase of the CLK_DIV=2 instance.
        pulse_start(24'(32'($urandom)));
        tick(40);
        check_eq("pre_rst_sclk", 32'(w_sclk[0]), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("rst_sclk", 32'(w_sclk), 32'd0);
        check_eq("rst_sda", 32'(w_sda), 32'd0);
        check_eq("rst_busy", 32'(w_busy), 32'd0);
        tick(3);
        reset = 1'b1;
        tick(2);
        pulse_start(24'h123456);
        tick(110);

        // Random payloads with random gaps and stray starts.
        repeat (6) begin
            tick($urandom_range(0, 5));
            pulse_start(24'(32'($urandom)));
            tick($urandom_range(1, 40));
            pulse_start(24'(32'($urandom)));
            tick(100);
        end

        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("valid_vs_done%0d", i), 32'(n_valid[i]), 32'(n_done[i]));
        end
        check_eq("frames_div2", 32'(n_done[0] > 10), 32'd1);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
